est_sync_dr_fifo: RTL



---
 rtl/est_sync_dr_fifo_pkg.sv | 40 ++++
 rtl/est_sync_dr_fifo_dr_detect.sv | 25 ++
 rtl/est_sync_dr_fifo.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/est_sync_dr_fifo_pkg.sv
// Shared types and dual-rail helpers for clocked dual-rail stages.
// Encoding: logical bit i maps to true rail [2i+1] and false rail [2i].
package est_sync_pkg;

  localparam int DR_MAX_W  = 64;
  localparam int DR_BUS_MAX = 2 * DR_MAX_W;

  typedef enum logic [0:0] {
    IN_DATA = 1'b0,
    IN_NULL = 1'b1
  } in_state_t;

  typedef enum logic [0:0] {
    OUT_NULL  = 1'b0,
    OUT_VALID = 1'b1
  } out_state_t;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Callers zero-extend narrower words and truncate the result to 2*WIDTH.
  function automatic logic [DR_BUS_MAX-1:0] dr_encode(input logic [DR_MAX_W-1:0] word);
    logic [DR_BUS_MAX-1:0] bus;
    for (int i = 0; i < DR_MAX_W; i++) begin
      bus[2*i+1] = word[i];
      bus[2*i]   = ~word[i];
    end
    return bus;
  endfunction

  function automatic logic [DR_MAX_W-1:0] dr_decode(input logic [DR_BUS_MAX-1:0] bus);
    logic [DR_MAX_W-1:0] word;
    for (int i = 0; i < DR_MAX_W; i++) begin
      word[i] = bus[2*i+1];
    end
    return word;
  endfunction

endpackage

// File: rtl/est_sync_dr_fifo_dr_detect.sv
// Completion / null / invalid detection for a WIDTH-bit dual-rail bus.
module dr_detect #(
  parameter int WIDTH = 4
) (
  input  logic [2*WIDTH-1:0] bus,
  output logic               complete,
  output logic               is_null,
  output logic               invalid
);

  logic [WIDTH-1:0] pair_one;
  logic [WIDTH-1:0] pair_both;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pair
      assign pair_one[gi]  = bus[2*gi+1] ^ bus[2*gi];
      assign pair_both[gi] = bus[2*gi+1] & bus[2*gi];
    end
  endgenerate

  assign complete = &pair_one;
  assign is_null  = ~|bus;
  assign invalid  = |pair_both;

endmodule

// File: rtl/est_sync_dr_fifo.sv
// Dual-rail in / dual-rail out FIFO bridging four-phase handshakes to clocked logic.
// Optional EST_SYNC_DR_FIFO_SYNC_IN_EN adds 2-flop synchronisers on data_in and ack_next.
module est_sync_dr_fifo
  import est_sync_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 4,
  parameter int               NUM_ACK   = 2,
  parameter bit               RST_TOKEN = 1'b1,
  parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [2*WIDTH-1:0]               data_in,
  output logic                             ack_ant,
  output logic [2*WIDTH-1:0]               data_out,
  input  logic [NUM_ACK-1:0]               ack_next,
  output logic [count_width(DEPTH)-1:0]    count,
  output logic                             err
);

  localparam int CW    = count_width(DEPTH);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] RST_WR_PTR = PTR_W'((RST_TOKEN && DEPTH > 1) ? 1 : 0);

  logic [2*WIDTH-1:0] din_s;
  logic [NUM_ACK-1:0] ack_s;

`ifdef EST_SYNC_DR_FIFO_SYNC_IN_EN
  logic [2*WIDTH-1:0] din_meta_reg, din_sync_reg;
  logic [NUM_ACK-1:0] ack_meta_reg, ack_sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      din_meta_reg <= '0;
      din_sync_reg <= '0;
      ack_meta_reg <= '0;
      ack_sync_reg <= '0;
    end else begin
      din_meta_reg <= data_in;
      din_sync_reg <= din_meta_reg;
      ack_meta_reg <= ack_next;
      ack_sync_reg <= ack_meta_reg;
    end
  end

  assign din_s = din_sync_reg;
  assign ack_s = ack_sync_reg;
`else
  assign din_s = data_in;
  assign ack_s = ack_next;
`endif

  logic din_complete, din_null, din_invalid;

  dr_detect #(.WIDTH(WIDTH)) u_detect (
    .bus      (din_s),
    .complete (din_complete),
    .is_null  (din_null),
    .invalid  (din_invalid)
  );

  logic [WIDTH-1:0] din_word;
  assign din_word = WIDTH'(dr_decode(DR_BUS_MAX'(din_s)));

  logic ack_all_one, ack_all_zero;
  assign ack_all_one  = &ack_s;
  assign ack_all_zero = ~|ack_s;

  logic [CW-1:0]    count_reg, count_next;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic             fifo_full, fifo_empty;

  assign fifo_full  = (count_reg >= CW'(DEPTH));
  assign fifo_empty = (count_reg == '0);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Input FSM
  in_state_t in_state_reg, in_state_next;
  logic      push_en;

  always_ff @(posedge clk) begin
    if (rst) in_state_reg <= IN_DATA;
    else     in_state_reg <= in_state_next;
  end

  always_comb begin
    in_state_next = in_state_reg;
    case (in_state_reg)
      IN_DATA: if (din_complete && !fifo_full) in_state_next = IN_NULL;
      IN_NULL: if (din_null)                   in_state_next = IN_DATA;
      default: in_state_next = IN_DATA;
    endcase
  end

  always_comb begin
    ack_ant = (in_state_reg == IN_NULL);
    push_en = (in_state_reg == IN_DATA) && din_complete && !fifo_full;
  end

  // Output FSM
  out_state_t out_state_reg, out_state_next;
  logic       load_en, pop_en;

  always_ff @(posedge clk) begin
    if (rst) out_state_reg <= OUT_NULL;
    else     out_state_reg <= out_state_next;
  end

  always_comb begin
    out_state_next = out_state_reg;
    case (out_state_reg)
      OUT_NULL:  if (!fifo_empty && ack_all_zero) out_state_next = OUT_VALID;
      OUT_VALID: if (ack_all_one)                 out_state_next = OUT_NULL;
      default:   out_state_next = OUT_NULL;
    endcase
  end

  always_comb begin
    load_en = (out_state_reg == OUT_NULL) && !fifo_empty && ack_all_zero;
    pop_en  = (out_state_reg == OUT_VALID) && ack_all_one;
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      if (RST_TOKEN) mem_reg[0] <= RST_VALUE;
    end else if (push_en) begin
      mem_reg[wr_ptr_reg] <= din_word;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push_en, pop_en})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  logic [2*WIDTH-1:0] data_out_reg;
  logic               err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg    <= CW'(RST_TOKEN);
      wr_ptr_reg   <= RST_WR_PTR;
      rd_ptr_reg   <= '0;
      data_out_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (push_en) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop_en)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      // The head is re-read at load time, so data_out never bypasses the array.
      if (load_en)     data_out_reg <= (2*WIDTH)'(dr_encode(DR_MAX_W'(mem_reg[rd_ptr_reg])));
      else if (pop_en) data_out_reg <= '0;
      if (din_invalid) err_reg <= 1'b1;
    end
  end

  assign data_out = data_out_reg;
  assign count    = count_reg;
  assign err      = err_reg;

endmodule
